seg7_encoder: RTL
=================

SEG7_ENCODER -- requirements
Module: seg7_encoder

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning the number of digits assembled per output word (legal range 1 to 8).
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have port seg_in, input, 7, active-low segment pattern; bit0=a, bit1=b ... bit6=g; 0 = segment lit.
REQ-005 SHALL have port seg_valid, input, 1, meaning seg_in carries a pattern this cycle.
REQ-006 SHALL have port seg_ready, output, 1, meaning the block accepts a pattern this cycle.
REQ-007 SHALL have port value, output, 4*DIGITS, the assembled hex word.
REQ-008 SHALL have port value_valid, output, 1, meaning value is complete and stable.
REQ-009 SHALL have port value_ack, input, 1, consumer release of value.
REQ-010 SHALL have port err, output, 1, one-cycle pulse flagging a rejected pattern.
REQ-011 SHALL have port digit_count, output, 4, the number of digits accepted into the current word.

Function
REQ-012 SHALL map patterns to nibbles as follows, in hex seg_in->nibble: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 18->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F.
REQ-013 SHALL treat every other 7-bit pattern as invalid, including 10 (9 with d lit).
REQ-014 SHALL implement a two-state FSM: COLLECT and HOLD.
REQ-015 SHALL drive seg_ready=1 in COLLECT and seg_ready=0 in HOLD, decoded from state only.
REQ-016 SHALL accept a pattern only on a cycle where seg_valid=1 and seg_ready=1; seg_valid in HOLD is ignored and produces no err.
REQ-017 SHALL, on acceptance of a valid pattern, update value to {value[4*DIGITS-5:0], nibble} and increment digit_count by 1 on the next edge, so the first digit ends up most significant.
REQ-018 SHALL, on acceptance of an invalid pattern, leave value and digit_count unchanged and assert err for exactly the following cycle.
REQ-019 SHALL, when the accepted valid pattern makes digit_count equal DIGITS, enter HOLD and assert value_valid on the next edge, giving 1 cycle of latency from the last accepted digit.
REQ-020 SHALL hold value, digit_count=DIGITS and value_valid=1 stable in HOLD until value_ack=1 is sampled.
REQ-021 SHALL, on value_ack=1 in HOLD, return to COLLECT with value=0, digit_count=0 and value_valid=0 on the next edge; seg_ready goes to 1 in that same cycle.
REQ-022 SHALL ignore value_ack in COLLECT.
REQ-023 SHALL not accept a digit on the HOLD->COLLECT transition cycle, because seg_ready is 0 in HOLD.
REQ-024 SHALL keep err=0 in all cycles except those specified in REQ-018.

Reset
REQ-025 SHALL, when resetn=0 at a clock edge, set state=COLLECT, value=0, digit_count=0, value_valid=0 and err=0.
REQ-026 SHALL give reset priority over acceptance and value_ack in the same cycle, discarding any partial word mid-collection.

Verification
REQ-027 SHALL verify the assembly order (DIGITS=4): reset, then patterns 79,24,30,19 on consecutive cycles with seg_valid=1 -> value_valid=1 one cycle after the 4th pattern, value=16'h1234, digit_count=4.
REQ-028 SHALL verify rejection of an invalid pattern: mid-word pattern 7F (blank) -> err=1 for one cycle, value and digit_count unchanged; the next pattern 12 is appended as 5.
REQ-029 SHALL verify backpressure in HOLD: with value_valid=1, seg_valid=1 held for 5 cycles with pattern 40 -> seg_ready=0, value unchanged, err=0; then value_ack=1 -> next cycle value=0, digit_count=0, value_valid=0, seg_ready=1.
REQ-030 SHALL verify the full 16-entry table: feed all 16 codes of REQ-012 in order across 4 words -> words 0123, 4567, 89AB, CDEF; also pattern 10 -> err=1.
REQ-031 SHALL verify reset mid-word: after 2 digits accepted, resetn=0 for one cycle -> value=0, digit_count=0; the next 4 valid digits form a complete word.
REQ-032 SHALL verify the parameter boundary: DIGITS=1, pattern 06 -> value=4'hE, value_valid=1 the next cycle.

Source files
------------

// File: rtl/seg7_encoder.sv
// ---------------------------------------------------------------------------
// seg7_encoder
//
// Purpose:
//   Decodes a stream of active-low seven-segment patterns back into hex
//   nibbles and assembles DIGITS of them into one output word. The first
//   digit accepted ends up in the most significant nibble. Once the word is
//   complete it is held, with value_valid raised, until the consumer releases
//   it with value_ack. Patterns that are not one of the 16 hex glyphs are
//   rejected with a one-cycle err pulse and leave the word untouched.
//
// Parameters:
//   DIGITS       number of digits per output word (1..8)
//
// Ports:
//   clock        single clock, rising-edge active
//   resetn       synchronous active-low reset
//   seg_in       active-low segment pattern, bit0=a .. bit6=g
//   seg_valid    seg_in carries a pattern this cycle
//   seg_ready    block accepts a pattern this cycle (high while collecting)
//   value        assembled hex word, 4*DIGITS bits
//   value_valid  value is complete and stable
//   value_ack    consumer release of value
//   err          one-cycle pulse after a rejected pattern
//   digit_count  digits accepted into the current word
// ---------------------------------------------------------------------------
module seg7_encoder #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [6:0]            seg_in,
  input  logic                  seg_valid,
  output logic                  seg_ready,
  output logic [4*DIGITS-1:0]   value,
  output logic                  value_valid,
  input  logic                  value_ack,
  output logic                  err,
  output logic [3:0]            digit_count
);

  localparam logic [3:0] LastCount = 4'(DIGITS);

  typedef enum logic [0:0] {
    StCollect,
    StHold
  } state_e;

  state_e                r_state;
  state_e                w_state_d;
  logic [4*DIGITS-1:0]   r_value;
  logic [4*DIGITS-1:0]   w_value_d;
  logic [4*DIGITS-1:0]   w_value_shift;
  logic [3:0]            r_count;
  logic [3:0]            w_count_d;
  logic [3:0]            w_count_inc;
  logic                  r_err;
  logic                  w_err_d;
  logic [3:0]            w_nibble;
  logic                  w_code_ok;
  logic                  w_accept;

  // Glyph decoder: exact match only, anything else is rejected.
  always_comb begin
    w_nibble  = 4'h0;
    w_code_ok = 1'b1;
    unique case (seg_in)
      7'h40:   w_nibble = 4'h0;
      7'h79:   w_nibble = 4'h1;
      7'h24:   w_nibble = 4'h2;
      7'h30:   w_nibble = 4'h3;
      7'h19:   w_nibble = 4'h4;
      7'h12:   w_nibble = 4'h5;
      7'h02:   w_nibble = 4'h6;
      7'h78:   w_nibble = 4'h7;
      7'h00:   w_nibble = 4'h8;
      7'h18:   w_nibble = 4'h9;
      7'h08:   w_nibble = 4'hA;
      7'h03:   w_nibble = 4'hB;
      7'h46:   w_nibble = 4'hC;
      7'h21:   w_nibble = 4'hD;
      7'h06:   w_nibble = 4'hE;
      7'h0E:   w_nibble = 4'hF;
      default: w_code_ok = 1'b0;
    endcase
  end

  // A single-digit word has nothing to shift; the nibble replaces it.
  if (DIGITS == 1) begin : g_shift_single
    assign w_value_shift = w_nibble;
  end else begin : g_shift_multi
    assign w_value_shift = {r_value[4*DIGITS-5:0], w_nibble};
  end

  assign w_count_inc = r_count + 4'd1;
  assign seg_ready   = (r_state == StCollect);
  assign w_accept    = seg_valid && seg_ready;

  always_comb begin
    w_state_d = r_state;
    w_value_d = r_value;
    w_count_d = r_count;
    w_err_d   = 1'b0;
    unique case (r_state)
      StCollect: begin
        if (w_accept) begin
          if (w_code_ok) begin
            w_value_d = w_value_shift;
            w_count_d = w_count_inc;
            if (w_count_inc == LastCount) begin
              w_state_d = StHold;
            end
          end else begin
            w_err_d = 1'b1;
          end
        end
      end
      StHold: begin
        if (value_ack) begin
          w_state_d = StCollect;
          w_value_d = '0;
          w_count_d = 4'd0;
        end
      end
      default: begin
        w_state_d = StCollect;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= StCollect;
      r_value <= '0;
      r_count <= 4'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_value <= w_value_d;
      r_count <= w_count_d;
      r_err   <= w_err_d;
    end
  end

  assign value       = r_value;
  assign digit_count = r_count;
  assign err         = r_err;
  // The word is complete exactly while holding.
  assign value_valid = (r_state == StHold);

endmodule
